uart_rx_port: RTL and testbench

UART_RX_PORT -- requirements
Module: uart_rx_port

---
 rtl/uart_rx_port.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_port.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_port.sv
// rtl/uart_rx_port.sv - 8N1 UART receiver with receive FIFO and a simple register bus port
//
// Purpose: samples the asynchronous serial line, assembles 8N1 frames, queues
// received bytes in a small circular FIFO and exposes them through a
// request/ready register port with a level interrupt.
//
// Ports:
//   clock, reset          single clock, asynchronous active-high reset
//   uart_valid            bus request strobe
//   uart_instr            instruction-fetch flag (unused)
//   uart_addr[31:0]       byte address, bits [3:0] decoded (0x0 data, 0x8 control)
//   uart_wdata[31:0]      write data
//   uart_wstrb[3:0]       byte write strobes, all zero = read
//   uart_rdata[31:0]      read data, valid with uart_ready, 0 otherwise
//   uart_ready            one-cycle completion pulse
//   uart_rx               serial input, idle high
//   uart_irq              level interrupt: enabled and data pending

module uart_rx_port #(
    parameter int clks_per_bit = 8680,
    parameter int fifo_depth   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    input  logic        uart_rx,
    output logic        uart_irq
);

    localparam int CW = $clog2(clks_per_bit);
    localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int NW = $clog2(fifo_depth + 1);

    localparam logic [CW-1:0] BIT_END  = CW'(clks_per_bit - 1);
    localparam logic [CW-1:0] HALF_END = CW'(clks_per_bit / 2 - 1);
    localparam logic [NW-1:0] FULL_CNT = NW'(fifo_depth);
    localparam logic [PW-1:0] PTR_LAST = PW'(fifo_depth - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Registered state
    logic          rx_meta_q, rx_s_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem_q [fifo_depth];
    logic [7:0]    mem_d [fifo_depth];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          irq_en_q, irq_en_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;

    // Combinational helpers
    logic          push;
    logic          req, is_read, data_read;
    logic [3:0]    offset;
    logic          nonempty, full, pop, do_write;
    logic [7:0]    head;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, uart_instr, uart_addr[31:4], uart_wdata[31:1]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Receive FSM; push is a one-cycle strobe on a good stop-bit sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus decode, FIFO bookkeeping and register updates
    always_comb begin
        req       = uart_valid && !ready_q;
        is_read   = (uart_wstrb == 4'b0000);
        offset    = uart_addr[3:0];
        data_read = req && is_read && (offset == 4'h0);
        nonempty  = (count_q != '0);
        full      = (count_q == FULL_CNT);
        head      = nonempty ? mem_q[rd_ptr_q] : 8'h00;
        pop       = data_read && nonempty;
        // A pop in the same cycle makes room, so a full FIFO still accepts the byte.
        do_write  = push && (!full || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_write && !pop) count_d = count_q + NW'(1);
        else if (!do_write && pop) count_d = count_q - NW'(1);

        // Reading the data register clears overrun, but a new overrun wins.
        overrun_d = (overrun_q && !data_read) || (push && full && !pop);

        irq_en_d = irq_en_q;
        if (req && !is_read && (offset == 4'h8) && uart_wstrb[0]) irq_en_d = uart_wdata[0];

        ready_d = req;
        rdata_d = 32'h0;
        if (req && is_read) begin
            if (offset == 4'h0) rdata_d = {22'b0, overrun_q, nonempty, head};
            else if (offset == 4'h8) rdata_d = {31'b0, irq_en_q};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            for (int i = 0; i < fifo_depth; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            irq_en_q  <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            irq_en_q  <= irq_en_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    assign uart_rdata = rdata_q;
    assign uart_ready = ready_q;
    assign uart_irq   = irq_en_q && (count_q != '0);

endmodule

// File: tb/tb_uart_rx_port.sv
// tb/tb_uart_rx_port.sv - directed self-checking bench for uart_rx_port

module tb_uart_rx_port;

    localparam int CPB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_valid = 1'b0;
    logic        uart_instr = 1'b0;
    logic [31:0] uart_addr = 32'h0;
    logic [31:0] uart_wdata = 32'h0;
    logic [3:0]  uart_wstrb = 4'h0;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_rx = 1'b1;
    logic        uart_irq;

    int checks = 0;
    int errors = 0;

    uart_rx_port #(.clks_per_bit(CPB), .fifo_depth(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .uart_valid (uart_valid),
        .uart_instr (uart_instr),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .uart_rx    (uart_rx),
        .uart_irq   (uart_irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output logic [31:0] rd);
        int n;
        uart_valid = 1'b1;
        uart_addr  = addr;
        uart_wdata = wdata;
        uart_wstrb = wstrb;
        @(negedge clock);
        uart_valid = 1'b0;
        n = 0;
        while (!uart_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_ready"}, {31'b0, uart_ready}, 32'h1);
        rd = uart_rdata;
        @(negedge clock);
        check({tag, "_idle_rdata"}, uart_rdata, 32'h0);
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus(tag, addr, 32'h0, 4'h0, rd);
        check(tag, rd, exp);
    endtask

    task automatic send_start_data(input logic [7:0] b);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_start_data(b);
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clock);
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        int n;

        repeat (3) @(negedge clock);
        check("rst_ready", {31'b0, uart_ready}, 32'h0);
        check("rst_rdata", uart_rdata, 32'h0);
        check("rst_irq", {31'b0, uart_irq}, 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Basic frame; writes to 0x0 and other offsets must not pop
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clock);
        bus("wr_data_reg", 32'h0, 32'hFFFF_FFFF, 4'hF, rd);
        check("wr_data_reg_rdata", rd, 32'h0);
        read_chk("rd_off4", 32'h4, 32'h0);
        read_chk("rd_a5", 32'h0, 32'h1A5);
        read_chk("rd_a5_empty", 32'h0, 32'h000);

        // Start-bit glitch
        uart_rx = 1'b0;
        repeat (5) @(negedge clock);
        uart_rx = 1'b1;
        repeat (40) @(negedge clock);
        read_chk("glitch", 32'h0, 32'h000);

        // Framing error then break, then a good frame
        send_frame(8'h00, 1'b0);
        uart_rx = 1'b0;
        repeat (40) @(negedge clock);
        uart_rx = 1'b1;
        repeat (20) @(negedge clock);
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge clock);
        read_chk("brk_3c", 32'h0, 32'h13C);
        read_chk("brk_empty", 32'h0, 32'h000);

        // Overrun
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            repeat (4) @(negedge clock);
        end
        read_chk("ovr_1", 32'h0, 32'h301);
        read_chk("ovr_2", 32'h0, 32'h102);
        read_chk("ovr_3", 32'h0, 32'h103);
        read_chk("ovr_4", 32'h0, 32'h104);
        read_chk("ovr_empty", 32'h0, 32'h000);

        // Interrupt timing: stop sample lands 10 cycles into the stop bit
        bus("wr_irq_en", 32'h8, 32'h1, 4'h1, rd);
        read_chk("rd_irq_en", 32'h8, 32'h1);
        check("irq_idle", {31'b0, uart_irq}, 32'h0);
        send_start_data(8'h7E);
        uart_rx = 1'b1;
        n = 0;
        while (!uart_irq && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("irq_rise_cycle", n, 11);
        repeat (10) @(negedge clock);
        read_chk("irq_7e", 32'h0, 32'h17E);
        check("irq_fall", {31'b0, uart_irq}, 32'h0);

        // Reset in the middle of data bit 4 of 0xFF
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        uart_rx = 1'b1;
        repeat (4 * CPB + CPB / 2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("mid_rst_ready", {31'b0, uart_ready}, 32'h0);
        check("mid_rst_irq", {31'b0, uart_irq}, 32'h0);
        reset = 1'b0;
        repeat (4 * CPB) @(negedge clock);
        read_chk("post_rst_count", 32'h0, 32'h000);
        read_chk("post_rst_irq_en", 32'h8, 32'h0);
        send_frame(8'h42, 1'b1);
        repeat (4) @(negedge clock);
        read_chk("post_rst_42", 32'h0, 32'h142);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
